// File: rtl/alu_mdu.sv
// alu_mdu: multi-cycle ALU with an iterative unsigned multiply/divide unit.
// Single-cycle ops finish one edge after issue. MULTU/DIVU with a nonzero
// divisor take WIDTH cycles, with busy high while they run. done pulses for
// one cycle each time result/hi/zero are written.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start, funct      issue request and operation select, sampled in IDLE only
//   shamt             immediate shift amount for SLL/SRL
//   srcA, srcB        operands, latched at issue
//   busy              an iterative op is in flight
//   done              one-cycle pulse when the outputs are written
//   result, hi, zero  primary result, product-high/remainder, result == 0
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero
);
    localparam logic [5:0] F_ADDU  = 6'b001001;
    localparam logic [5:0] F_SUBU  = 6'b001010;
    localparam logic [5:0] F_SLL   = 6'b100001;
    localparam logic [5:0] F_SRL   = 6'b100010;
    localparam logic [5:0] F_SLLV  = 6'b110101;
    localparam logic [5:0] F_SRLV  = 6'b110110;
    localparam logic [5:0] F_SLTI  = 6'b101010;
    localparam logic [5:0] F_SLT   = 6'b101011;
    localparam logic [5:0] F_MULTU = 6'b011000;
    localparam logic [5:0] F_DIVU  = 6'b011010;

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_EXEC = 1'b1;

    logic                 state;
    logic [SHW-1:0]       cnt;
    logic                 op_div;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    // MULTU: running product. DIVU: {partial remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   addend;
    logic [WIDTH:0]       trial;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     alu_res;
    logic                 is_md;
    logic                 div_by_zero;

    assign busy        = (state == STATE_EXEC);
    assign is_md       = (funct == F_MULTU) || (funct == F_DIVU);
    assign div_by_zero = (funct == F_DIVU) && (srcB == '0);

    always_comb begin
        alu_res = '0;
        case (funct)
            F_ADDU: alu_res = srcA + srcB;
            F_SUBU: alu_res = srcA - srcB;
            F_SLL:  alu_res = srcA << shamt;
            F_SRL:  alu_res = srcA >> shamt;
            F_SLLV: alu_res = srcA << srcB[SHW-1:0];
            F_SRLV: alu_res = srcA >> srcB[SHW-1:0];
            F_SLTI: alu_res = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
            F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            default: alu_res = '0;
        endcase
    end

    // Multiply walks B from its MSB (opb is shifted left each cycle), so the
    // product is doubled then conditionally incremented by A. Divide shifts
    // the next dividend bit into the remainder and restores on a failed trial.
    always_comb begin
        addend   = opb[WIDTH-1] ? {{WIDTH{1'b0}}, opa} : '0;
        trial    = acc[2*WIDTH-1:WIDTH-1];
        diff     = trial - {1'b0, opb};
        acc_next = '0;
        if (op_div) begin
            if (trial >= {1'b0, opb})
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {acc[2*WIDTH-2:0], 1'b0} + addend;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= STATE_IDLE;
            cnt    <= '0;
            op_div <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            done   <= 1'b0;
            result <= '0;
            hi     <= '0;
            zero   <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    if (start) begin
                        if (is_md && !div_by_zero) begin
                            opa    <= srcA;
                            opb    <= srcB;
                            op_div <= (funct == F_DIVU);
                            acc    <= (funct == F_DIVU) ? {{WIDTH{1'b0}}, srcA} : '0;
                            cnt    <= '0;
                            state  <= STATE_EXEC;
                        end else if (div_by_zero) begin
                            result <= '1;
                            hi     <= srcA;
                            zero   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            result <= alu_res;
                            zero   <= (alu_res == '0);
                            done   <= 1'b1;
                        end
                    end
                end
                default: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (!op_div)
                        opb <= opb << 1;
                    if (cnt == SHW'(WIDTH - 1)) begin
                        result <= acc_next[WIDTH-1:0];
                        hi     <= acc_next[2*WIDTH-1:WIDTH];
                        zero   <= (acc_next[WIDTH-1:0] == '0);
                        done   <= 1'b1;
                        state  <= STATE_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed and randomized checks of alu_mdu (WIDTH = 32)
// against an arithmetic reference model.
module tb_alu_mdu;
    localparam int W = 32;

    localparam logic [5:0] F_ADDU  = 6'b001001;
    localparam logic [5:0] F_SUBU  = 6'b001010;
    localparam logic [5:0] F_SLL   = 6'b100001;
    localparam logic [5:0] F_SRL   = 6'b100010;
    localparam logic [5:0] F_SLLV  = 6'b110101;
    localparam logic [5:0] F_SRLV  = 6'b110110;
    localparam logic [5:0] F_SLTI  = 6'b101010;
    localparam logic [5:0] F_SLT   = 6'b101011;
    localparam logic [5:0] F_MULTU = 6'b011000;
    localparam logic [5:0] F_DIVU  = 6'b011010;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [5:0]    funct;
    logic [4:0]    shamt;
    logic [W-1:0]  srcA;
    logic [W-1:0]  srcB;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic [W-1:0]  hi;
    logic          zero;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] m_hi;

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .funct(funct), .shamt(shamt),
        .srcA(srcA), .srcB(srcB), .busy(busy), .done(done),
        .result(result), .hi(hi), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble the inputs right after issue, wait for done and
    // compare against the model; then check done drops and outputs hold.
    task automatic do_op(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] sh);
        logic [W-1:0]   er;
        logic [W-1:0]   eh;
        logic [2*W-1:0] p;
        int elat, lat, nbusy, both;
        eh   = m_hi;
        elat = 0;
        case (f)
            F_ADDU:  er = a + b;
            F_SUBU:  er = a - b;
            F_SLL:   er = a << sh;
            F_SRL:   er = a >> sh;
            F_SLLV:  er = a << (b % W);
            F_SRLV:  er = a >> (b % W);
            F_SLTI:  er = (a < b) ? 1 : 0;
            F_SLT:   er = ($signed(a) < $signed(b)) ? 1 : 0;
            F_MULTU: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                er = p[W-1:0]; eh = p[2*W-1:W]; elat = W;
            end
            F_DIVU: begin
                if (b == 0) begin er = '1; eh = a; end
                else begin er = a / b; eh = a % b; elat = W; end
            end
            default: er = '0;
        endcase
        m_hi = eh;

        funct = f; srcA = a; srcB = b; shamt = sh; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        srcA = $urandom; srcB = $urandom; funct = 6'($urandom); shamt = 5'($urandom);
        lat = 0; nbusy = 0; both = 0;
        while (!done && lat < 100) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        if (done && busy) both = 1;
        check($sformatf("%s.latency", tag), 64'(lat), 64'(elat));
        check($sformatf("%s.busy_cycles", tag), 64'(nbusy), 64'(elat));
        check($sformatf("%s.busy_with_done", tag), 64'(both), 64'd0);
        check($sformatf("%s.result", tag), 64'(result), 64'(er));
        check($sformatf("%s.hi", tag), 64'(hi), 64'(eh));
        check($sformatf("%s.zero", tag), 64'(zero), 64'(er == 0));
        @(posedge clk); #1;
        check($sformatf("%s.done_low", tag), 64'(done), 64'd0);
        check($sformatf("%s.hold", tag), 64'(result), 64'(er));
    endtask

    logic [5:0] codes [11];
    int ndone, lat;
    logic [W-1:0] cap_res, cap_hi;

    initial begin
        codes = '{F_ADDU, F_SUBU, F_SLL, F_SRL, F_SLLV, F_SRLV, F_SLTI, F_SLT,
                  F_MULTU, F_DIVU, 6'b111111};
        rst = 1'b1; start = 1'b0; funct = '0; shamt = '0; srcA = '0; srcB = '0;
        m_hi = '0;
        #12;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.result", 64'(result), 64'd0);
        check("reset.hi", 64'(hi), 64'd0);
        check("reset.zero", 64'(zero), 64'd1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        do_op("addu_wrap", F_ADDU, 32'hFFFF_FFFF, 32'd1, 5'd0);
        do_op("subu_under", F_SUBU, 32'd0, 32'd1, 5'd0);
        do_op("sllv_mask", F_SLLV, 32'd1, 32'd33, 5'd0);
        do_op("srl_31", F_SRL, 32'h8000_0000, 32'd0, 5'd31);
        do_op("slt_neg", F_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
        do_op("slti_uns", F_SLTI, 32'hFFFF_FFFF, 32'd1, 5'd0);
        do_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        do_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 5'd0);
        do_op("divu_by0", F_DIVU, 32'h1234_5678, 32'd0, 5'd0);
        do_op("unknown", 6'b000000, 32'd5, 32'd6, 5'd0);

        // Back-to-back single-cycle issues on consecutive edges.
        funct = F_ADDU; srcA = 32'd1; srcB = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        check("b2b.first_done", 64'(done), 64'd1);
        check("b2b.first_res", 64'(result), 64'd3);
        funct = F_SUBU; srcA = 32'd10; srcB = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b.second_done", 64'(done), 64'd1);
        check("b2b.second_res", 64'(result), 64'd6);

        // start during busy must be ignored.
        funct = F_MULTU; srcA = 32'd3; srcB = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        funct = F_ADDU; srcA = 32'd7; srcB = 32'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; lat = 5; cap_res = '0; cap_hi = '1;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    cap_res = result; cap_hi = hi;
                    check("ignore.latency", 64'(lat), 64'(W));
                end
            end
            @(posedge clk); #1;
            lat++;
        end
        m_hi = '0;
        check("ignore.done_count", 64'(ndone), 64'd1);
        check("ignore.result", 64'(cap_res), 64'd15);
        check("ignore.hi", 64'(cap_hi), 64'd0);

        // Load nonzero outputs, then reset in the middle of a DIVU.
        do_op("pre_reset_div", F_DIVU, 32'hDEAD_BEEF, 32'd0, 5'd0);
        funct = F_DIVU; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("midrst.busy_before", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst.busy", 64'(busy), 64'd0);
        check("midrst.done", 64'(done), 64'd0);
        check("midrst.result", 64'(result), 64'd0);
        check("midrst.hi", 64'(hi), 64'd0);
        check("midrst.zero", 64'(zero), 64'd1);
        @(negedge clk); rst = 1'b0;
        m_hi = '0;
        ndone = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("midrst.no_activity", 64'(ndone), 64'd0);
        do_op("post_rst_addu", F_ADDU, 32'd2, 32'd2, 5'd0);

        // Randomized operations over all codes plus an unknown one.
        for (int i = 0; i < 50; i++) begin
            logic [5:0]   f;
            logic [W-1:0] a, b;
            f = codes[$urandom_range(10, 0)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(5, 0))
                0: b = '0;
                1: b = 32'($urandom_range(9, 1));
                2: a = '0;
                default: ;
            endcase
            do_op($sformatf("rand%0d", i), f, a, b, 5'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
